// File: rtl/axi_ram_flow_pkg.sv
// Shared definitions for the DDR ring-buffer flow scheduler.
// Latency: n/a (types and constant helpers only).
// Backpressure: n/a.
// Contents: FSM state encoding (also the encoding of the 2-bit state output)
//           and the usable-capacity (LIMIT) helper.
package axi_ram_flow_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PREFILL = 2'd1,
    ST_RUN     = 2'd2,
    ST_DRAIN   = 2'd3
  } state_e;

  // Usable ring capacity: full ring minus the guard band kept free so the
  // writer can never catch up with the reader's tail.
  function automatic longint unsigned calc_limit(input int unsigned addr_width,
                                                 input int unsigned guard);
    return (64'd1 << addr_width) - 64'(guard);
  endfunction

endpackage

// File: rtl/axi_ram_occupancy.sv
// Ring occupancy tracker: registers both progress pointers and derives fill flags.
// Latency: occupancy and flags reflect the sts inputs one cycle later.
// Backpressure: none; free-running observer of the pointers.
// Ports: aclk/aresetn; wr_sts/rd_sts progress pointers; prefill_cfg threshold;
//        occupancy (wr - rd mod 2^ADDR_WIDTH); zero_occ, over_limit, ge_prefill flags.
module axi_ram_occupancy
  import axi_ram_flow_pkg::*;
#(
  parameter int unsigned            ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0]  LIMIT      = '1
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [ADDR_WIDTH-1:0] wr_sts,
  input  logic [ADDR_WIDTH-1:0] rd_sts,
  input  logic [ADDR_WIDTH-1:0] prefill_cfg,
  output logic [ADDR_WIDTH-1:0] occupancy,
  output logic                  zero_occ,
  output logic                  over_limit,
  output logic                  ge_prefill
);

  logic [ADDR_WIDTH-1:0] wr_q;
  logic [ADDR_WIDTH-1:0] rd_q;
  logic [ADDR_WIDTH-1:0] prefill_lim;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_sts;
      rd_q <= rd_sts;
    end
  end

  // Same-width subtraction wraps naturally, giving the modulo distance.
  assign occupancy   = wr_q - rd_q;
  assign zero_occ    = (occupancy == '0);
  assign over_limit  = (occupancy > LIMIT);
  // A threshold above the usable capacity could never be reached; clamp it.
  assign prefill_lim = (prefill_cfg > LIMIT) ? LIMIT : prefill_cfg;
  assign ge_prefill  = (occupancy >= prefill_lim);

endmodule

// File: rtl/axi_ram_flow_scheduler.sv
// Sequences a DDR ring writer/reader pair via their limit pointers (IDLE/PREFILL/RUN/DRAIN).
// Latency: cfg outputs follow an sts change after 1 cycle; occupancy-driven decisions after 2.
// Backpressure: stalls writer at rd+LIMIT and reader at the writer pointer; no ready handshake.
// Ports: aclk/aresetn; start/stop pulses; base_addr, prefill_cfg; writer/reader sts pointers in;
//        min_addr_*, sample_count_cfg_* out; occupancy, state, underrun, overrun, done status.
// Optional: define AXI_RAM_FLOW_STATS_EN to add peak_occupancy and stall_cycles outputs.
module axi_ram_flow_scheduler
  import axi_ram_flow_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned GUARD          = 16
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic                      start,
  input  logic                      stop,
  input  logic [AXI_ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0]     prefill_cfg,
  input  logic [ADDR_WIDTH-1:0]     sample_count_sts_writer,
  input  logic [ADDR_WIDTH-1:0]     sample_count_sts_reader,
  output logic [AXI_ADDR_WIDTH-1:0] min_addr_writer,
  output logic [AXI_ADDR_WIDTH-1:0] min_addr_reader,
  output logic [ADDR_WIDTH-1:0]     sample_count_cfg_writer,
  output logic [ADDR_WIDTH-1:0]     sample_count_cfg_reader,
  output logic [ADDR_WIDTH-1:0]     occupancy,
  output logic [1:0]                state,
  output logic                      underrun,
  output logic                      overrun,
  output logic                      done
`ifdef AXI_RAM_FLOW_STATS_EN
  ,
  output logic [ADDR_WIDTH-1:0]     peak_occupancy,
  output logic [31:0]               stall_cycles
`endif
);

  localparam logic [ADDR_WIDTH-1:0] LIMIT = ADDR_WIDTH'(calc_limit(ADDR_WIDTH, GUARD));

  logic                      zero_occ;
  logic                      over_limit;
  logic                      ge_prefill;
  logic                      start_acc;
  state_e                    state_q;
  logic [AXI_ADDR_WIDTH-1:0] min_addr_q;
  logic [ADDR_WIDTH-1:0]     cfg_w_q;
  logic [ADDR_WIDTH-1:0]     cfg_r_q;
  logic [ADDR_WIDTH-1:0]     wr_lim;
  logic                      underrun_q;
  logic                      overrun_q;
  logic                      done_q;

  axi_ram_occupancy #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .LIMIT      (LIMIT)
  ) u_occ (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .wr_sts      (sample_count_sts_writer),
    .rd_sts      (sample_count_sts_reader),
    .prefill_cfg (prefill_cfg),
    .occupancy   (occupancy),
    .zero_occ    (zero_occ),
    .over_limit  (over_limit),
    .ge_prefill  (ge_prefill)
  );

  assign start_acc = (state_q == ST_IDLE) && start && !stop;
  // Writer may run up to LIMIT samples ahead of the reader (wraps mod ring size).
  assign wr_lim    = sample_count_sts_reader + LIMIT;

  // cfg registers are loaded with the values belonging to the state being
  // entered, so state and cfg outputs always change on the same edge.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= ST_IDLE;
      min_addr_q <= '0;
      cfg_w_q    <= '0;
      cfg_r_q    <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_acc) begin
            state_q    <= ST_PREFILL;
            min_addr_q <= base_addr;
            cfg_w_q    <= wr_lim;
          end else begin
            cfg_w_q    <= sample_count_sts_writer;
          end
          cfg_r_q <= sample_count_sts_reader;
        end
        ST_PREFILL, ST_RUN: begin
          if (stop) begin
            // Freeze both limits at the writer position seen on stop.
            state_q <= ST_DRAIN;
            cfg_w_q <= sample_count_sts_writer;
            cfg_r_q <= sample_count_sts_writer;
          end else begin
            cfg_w_q <= wr_lim;
            if (state_q == ST_RUN || ge_prefill) begin
              state_q <= ST_RUN;
              cfg_r_q <= sample_count_sts_writer;
            end else begin
              cfg_r_q <= sample_count_sts_reader;
            end
          end
        end
        ST_DRAIN: begin
          if (zero_occ) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
            cfg_w_q <= sample_count_sts_writer;
            cfg_r_q <= sample_count_sts_reader;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      underrun_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else if (start_acc) begin
      underrun_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      if (state_q == ST_RUN && zero_occ) underrun_q <= 1'b1;
      if (over_limit)                    overrun_q  <= 1'b1;
    end
  end

`ifdef AXI_RAM_FLOW_STATS_EN
  logic [ADDR_WIDTH-1:0] peak_q;
  logic [31:0]           stall_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      peak_q  <= '0;
      stall_q <= '0;
    end else if (start_acc) begin
      peak_q  <= '0;
      stall_q <= '0;
    end else begin
      if (occupancy > peak_q) peak_q <= occupancy;
      if (state_q == ST_RUN && zero_occ && stall_q != '1) stall_q <= stall_q + 32'd1;
    end
  end

  assign peak_occupancy = peak_q;
  assign stall_cycles   = stall_q;
`else
  // Statistics counters are not built in this configuration.
`endif

  assign state                   = state_q;
  assign min_addr_writer         = min_addr_q;
  assign min_addr_reader         = min_addr_q;
  assign sample_count_cfg_writer = cfg_w_q;
  assign sample_count_cfg_reader = cfg_r_q;
  assign underrun                = underrun_q;
  assign overrun                 = overrun_q;
  assign done                    = done_q;

endmodule

// File: tb/tb_axi_ram_flow_scheduler.sv
module tb_axi_ram_flow_scheduler;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [31:0] base_addr = '0;
  logic [7:0]  prefill_cfg = '0;
  logic [7:0]  wr_s = '0;
  logic [7:0]  rd_s = '0;
  logic [31:0] min_w, min_r;
  logic [7:0]  cfg_w, cfg_r, occ;
  logic [1:0]  st;
  logic        under, over, dn;
`ifdef AXI_RAM_FLOW_STATS_EN
  logic [7:0]  peak;
  logic [31:0] stall;
`endif

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: behavioural view of the ring (ints, mod-256 arithmetic).
  int m_state, m_occ, m_cfgw, m_cfgr, m_freeze, m_peak, m_stall;
  bit m_under, m_over, m_done;
  logic [31:0] m_min;

  always #5 aclk = ~aclk;

  axi_ram_flow_scheduler #(.ADDR_WIDTH(8), .AXI_ADDR_WIDTH(32), .GUARD(16)) dut (
    .aclk(aclk), .aresetn(aresetn), .start(start), .stop(stop),
    .base_addr(base_addr), .prefill_cfg(prefill_cfg),
    .sample_count_sts_writer(wr_s), .sample_count_sts_reader(rd_s),
    .min_addr_writer(min_w), .min_addr_reader(min_r),
    .sample_count_cfg_writer(cfg_w), .sample_count_cfg_reader(cfg_r),
    .occupancy(occ), .state(st), .underrun(under), .overrun(over), .done(dn)
`ifdef AXI_RAM_FLOW_STATS_EN
    , .peak_occupancy(peak), .stall_cycles(stall)
`endif
  );

  task automatic model_reset();
    m_state = 0; m_occ = 0; m_cfgw = 0; m_cfgr = 0; m_freeze = 0;
    m_peak = 0; m_stall = 0; m_under = 0; m_over = 0; m_done = 0; m_min = '0;
  endtask

  // Advance the model by one clock using the inputs seen at this edge.
  task automatic model_step();
    int ns, pf, w, r;
    bit acc;
    w = int'(wr_s); r = int'(rd_s);
    acc = (m_state == 0) && start && !stop;
    pf = (int'(prefill_cfg) > 240) ? 240 : int'(prefill_cfg);
    ns = m_state; m_done = 0;
    if (m_state == 0 && acc) ns = 1;
    else if ((m_state == 1 || m_state == 2) && stop) ns = 3;
    else if (m_state == 1 && m_occ >= pf) ns = 2;
    else if (m_state == 3 && m_occ == 0) begin ns = 0; m_done = 1; end
    if (ns == 0)      begin m_cfgw = w; m_cfgr = r; end
    else if (ns == 1) begin m_cfgw = (r + 240) % 256; m_cfgr = r; end
    else if (ns == 2) begin m_cfgw = (r + 240) % 256; m_cfgr = w; end
    else begin
      if (m_state != 3) m_freeze = w;
      m_cfgw = m_freeze; m_cfgr = m_freeze;
    end
    if (acc) begin
      m_min = base_addr; m_under = 0; m_over = 0; m_peak = 0; m_stall = 0;
    end else begin
      if (m_state == 2 && m_occ == 0) begin
        m_under = 1;
        m_stall++;
      end
      if (m_occ > 240) m_over = 1;
      if (m_occ > m_peak) m_peak = m_occ;
    end
    m_occ = (w - r + 256) % 256;
    m_state = ns;
  endtask

  task automatic tick();
    @(posedge aclk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    aresetn = 0; wr_s = 0; rd_s = 0;
    model_reset();
    #2;
    if (st !== 2'd0)    begin n_fail++; $display("FAIL reset_state got %0d want 0", st); end
    n_cmp++;
    if (cfg_w !== 8'd0 || cfg_r !== 8'd0) begin n_fail++; $display("FAIL reset_cfg got %0d/%0d want 0/0", cfg_w, cfg_r); end
    n_cmp++;
    if (occ !== 8'd0 || under !== 1'b0 || over !== 1'b0 || dn !== 1'b0) begin
      n_fail++; $display("FAIL reset_status got occ=%0d u=%0b o=%0b d=%0b want 0", occ, under, over, dn); end
    n_cmp++;
    if (min_w !== 32'd0 || min_r !== 32'd0) begin n_fail++; $display("FAIL reset_addr got %h/%h want 0", min_w, min_r); end
    n_cmp++;
    #1 aresetn = 1;
    tick(); tick();
    if (st !== 2'd0 || cfg_w !== 8'd0) begin n_fail++; $display("FAIL idle_after_reset got st=%0d cfgw=%0d want 0/0", st, cfg_w); end
    n_cmp++;
  endtask

  task automatic test_prefill_zero();
    prefill_cfg = 0; start = 1;
    tick();
    start = 0;
    if (st !== 2'd1) begin n_fail++; $display("FAIL pf0_cycle1 got %0d want 1", st); end
    n_cmp++;
    tick();
    if (st !== 2'd2 || int'(st) != m_state) begin n_fail++; $display("FAIL pf0_run got %0d want 2", st); end
    n_cmp++;
    // Leave via drain back to IDLE (buffer is empty).
    stop = 1; tick(); stop = 0;
    for (int i = 0; i < 3; i++) tick();
    if (st !== 2'd0) begin n_fail++; $display("FAIL pf0_back_idle got %0d want 0", st); end
    n_cmp++;
  endtask

  task automatic test_prefill();
    int bad;
    base_addr = 32'h1000_0000; prefill_cfg = 64; wr_s = 0; rd_s = 0;
    tick();
    start = 1; tick(); start = 0;
    bad = 0;
    for (int w = 0; w < 64; w++) begin
      wr_s = 8'(w);
      tick();
      if (st !== 2'd1 || cfg_r !== 8'd0 || int'(cfg_w) != m_cfgw) bad++;
    end
    if (bad != 0) begin n_fail++; $display("FAIL prefill_hold got %0d bad cycles want 0", bad); end
    n_cmp++;
    wr_s = 64; tick(); tick();
    if (st !== 2'd2 || cfg_r !== 8'd64) begin n_fail++; $display("FAIL prefill_release got st=%0d cfgr=%0d want 2/64", st, cfg_r); end
    n_cmp++;
    if (min_w !== 32'h1000_0000 || min_r !== 32'h1000_0000 || min_w !== m_min) begin
      n_fail++; $display("FAIL prefill_addr got %h/%h want 10000000", min_w, min_r); end
    n_cmp++;
  endtask

  task automatic test_wrap();
    rd_s = 250; wr_s = 20;
    tick(); tick();
    if (occ !== 8'd26) begin n_fail++; $display("FAIL wrap_occ got %0d want 26", occ); end
    n_cmp++;
    if (cfg_w !== 8'd234 || cfg_r !== 8'd20) begin n_fail++; $display("FAIL wrap_cfg got %0d/%0d want 234/20", cfg_w, cfg_r); end
    n_cmp++;
  endtask

  task automatic test_random_run();
    int w, r, o, bad;
    w = int'(wr_s); r = int'(rd_s); bad = 0;
    for (int i = 0; i < 300; i++) begin
      o = (w - r + 256) % 256;
      r = (r + int'($urandom_range(o, 0))) % 256;
      o = (w - r + 256) % 256;
      w = (w + int'($urandom_range(240 - o, 0))) % 256;
      wr_s = 8'(w); rd_s = 8'(r);
      tick();
      if (int'(occ) != m_occ || int'(cfg_w) != m_cfgw || int'(cfg_r) != m_cfgr ||
          int'(st) != m_state || under !== m_under || over !== m_over) begin
        bad++;
        if (bad < 4) $display("FAIL rand_cycle%0d got occ=%0d cw=%0d cr=%0d st=%0d want %0d %0d %0d %0d",
                              i, occ, cfg_w, cfg_r, st, m_occ, m_cfgw, m_cfgr, m_state);
      end
    end
    if (bad != 0) n_fail++;
    n_cmp++;
`ifdef AXI_RAM_FLOW_STATS_EN
    if (int'(peak) != m_peak) begin n_fail++; $display("FAIL rand_peak got %0d want %0d", peak, m_peak); end
    n_cmp++;
`endif
  endtask

  task automatic test_underrun();
    wr_s = 100; rd_s = 100;
    for (int i = 0; i < 4; i++) tick();
    if (under !== 1'b1 || st !== 2'd2) begin n_fail++; $display("FAIL underrun_set got u=%0b st=%0d want 1/2", under, st); end
    n_cmp++;
    wr_s = 110; tick(); tick();
    if (under !== 1'b1) begin n_fail++; $display("FAIL underrun_sticky got %0b want 1", under); end
    n_cmp++;
`ifdef AXI_RAM_FLOW_STATS_EN
    if (int'(stall) != m_stall || stall < 32'd3) begin n_fail++; $display("FAIL stall_cycles got %0d want %0d", stall, m_stall); end
    n_cmp++;
`endif
  endtask

  task automatic test_drain();
    int dones, r;
    wr_s = 180; rd_s = 150; tick(); tick();
    stop = 1; tick(); stop = 0;
    if (st !== 2'd3 || cfg_w !== 8'd180 || cfg_r !== 8'd180) begin
      n_fail++; $display("FAIL drain_enter got st=%0d cw=%0d cr=%0d want 3/180/180", st, cfg_w, cfg_r); end
    n_cmp++;
    wr_s = 200; // writer position beyond the freeze must not move the limits
    r = 150; dones = 0;
    for (int i = 0; i < 60; i++) begin
      if (r < 180) r = r + int'($urandom_range(3, 0));
      if (r > 180) r = 180;
      rd_s = 8'(r);
      if (r == 180) wr_s = 180;
      tick();
      if (dn === 1'b1) dones++;
      if (st == 2'd3 && (cfg_w !== 8'd180 || cfg_r !== 8'd180)) dones += 100;
    end
    if (dones != 1 || st !== 2'd0) begin n_fail++; $display("FAIL drain_done got pulses=%0d st=%0d want 1/0", dones, st); end
    n_cmp++;
    start = 1; stop = 1; tick(); start = 0; stop = 0;
    tick();
    if (st !== 2'd0 || under !== 1'b1) begin n_fail++; $display("FAIL start_stop_idle got st=%0d u=%0b want 0/1", st, under); end
    n_cmp++;
    prefill_cfg = 0; base_addr = $urandom;
    start = 1; tick(); start = 0;
    if (under !== 1'b0 || min_w !== m_min) begin n_fail++; $display("FAIL restart_clear got u=%0b addr=%h want 0/%h", under, min_w, m_min); end
    n_cmp++;
    tick();
  endtask

  task automatic test_overrun_abort();
    wr_s = rd_s + 8'd241; tick(); tick();
    if (over !== 1'b1 || st !== 2'd2) begin n_fail++; $display("FAIL overrun got o=%0b st=%0d want 1/2", over, st); end
    n_cmp++;
    #2 aresetn = 0;
    model_reset();
    #1;
    if (st !== 2'd0 || cfg_w !== 8'd0 || cfg_r !== 8'd0 || occ !== 8'd0 || over !== 1'b0 || min_w !== 32'd0) begin
      n_fail++; $display("FAIL abort got st=%0d cw=%0d cr=%0d occ=%0d o=%0b want all 0", st, cfg_w, cfg_r, occ, over); end
    n_cmp++;
    #1 aresetn = 1;
    wr_s = 7; rd_s = 3;
    tick(); tick();
    if (int'(cfg_w) != m_cfgw || int'(occ) != m_occ || st !== 2'd0) begin
      n_fail++; $display("FAIL post_abort got cw=%0d occ=%0d want %0d/%0d", cfg_w, occ, m_cfgw, m_occ); end
    n_cmp++;
  endtask

  initial begin
    test_reset();
    test_prefill_zero();
    test_prefill();
    test_wrap();
    test_random_run();
    test_underrun();
    test_drain();
    test_overrun_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
